freq_synth: RTL
===============

Name: freq_synth

Overview:
Programmable square-wave clock generator: the transmit-side counterpart of the gated frequency counter. Accepts a target frequency in Hz and computes a phase-accumulator tuning word with an on-chip serial divider. It then drives clk_gen_out at that frequency from sys_clk. It produces test/reference clocks (10 kHz–500 kHz) for the DPLL and the frequency counter on the same board.

Parameters:
SYS_CLK_FREQ, 2000000, sys_clk frequency in Hz (divisor of the tuning-word division)
ACC_W, 24, phase accumulator / tuning word width in bits
F_MIN, 10000, lowest accepted request in Hz
F_MAX, 500000, highest accepted request in Hz; must be <= SYS_CLK_FREQ/4

Ports:
sys_clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
freq_req  in  32  requested frequency in Hz
req_valid  in  1  request strobe; accepted when req_valid & req_ready at a sys_clk edge
req_ready  out  1  high only in IDLE
busy  out  1  high in CALC and LOAD
load_done  out  1  one-cycle pulse, the cycle after a new tuning word takes effect
req_err  out  1  one-cycle pulse, request rejected (out of range)
cur_freq  out  32  frequency (Hz) of the currently loaded tuning word
clk_gen_out  out  1  generated clock (registered accumulator MSB)
tick  out  1  one-cycle pulse on each rising edge of clk_gen_out

Behaviour:
- Reset (rst_n low, asynchronous): state=IDLE, tw=0, acc=0, cur_freq=0, clk_gen_out=0, tick=0, load_done=0, req_err=0, busy=0, req_ready=1 after release. With tw=0 the output stays low.
- Accumulator: every cycle acc <= acc + tw, mod 2^ACC_W, wrap-around intended. clk_gen_out <= acc[ACC_W-1]. tick=1 for the one cycle in which clk_gen_out goes 0->1.
- Tuning word: tw = floor(freq_req * 2^ACC_W / SYS_CLK_FREQ), exact and truncating.
- FSM, three states:
  - IDLE:
    - On accept with F_MIN <= freq_req <= F_MAX: latch freq_req, set rem=freq_req, q=0, bit counter=ACC_W-1, go to CALC.
    - On accept out of range: pulse req_err the next cycle, stay in IDLE, leave tw and cur_freq unchanged.
  - CALC: restoring division, one quotient bit per cycle.
    - Per cycle: r2 = rem<<1. If r2 >= SYS_CLK_FREQ then rem = r2 - SYS_CLK_FREQ and q bit = 1, else rem = r2 and q bit = 0. Bits fill MSB first.
    - rem needs 33 bits since it is < 2*SYS_CLK_FREQ. Exactly ACC_W cycles, then go to LOAD.
  - LOAD: tw <= q and cur_freq <= latched frequency, one cycle, then IDLE. load_done is pulsed in the following cycle.
- Latency: request accepted at edge k; tw updated at edge k+ACC_W+1; load_done high during cycle k+ACC_W+2. req_ready is low for ACC_W+1 cycles.
- Update is phase-continuous: acc is not touched on LOAD, so there is no glitch or runt pulse beyond the natural accumulator behaviour.
- req_valid is ignored while busy; the requester must hold or re-issue. There is no queue.
- rst_n asserted mid-CALC: aborts immediately, all registers return to reset values, and the partial quotient is discarded.
- freq_req is sampled only at acceptance; later changes have no effect on the running division.

Optional Feature:
FREQ_SYNTH_PHASE_RST_EN:
- Defined: in the LOAD cycle acc <= 0 instead of acc + tw, so each new frequency starts at phase 0. clk_gen_out is low for at least one cycle after LOAD and the first tick comes a deterministic number of cycles after load_done.
- Not defined: phase-continuous update as above.

Test Plan:
- Reset, then request 125000 with defaults: req_err=0. After 25 cycles tw=1048576 and cur_freq=125000. clk_gen_out has period exactly 16 cycles (8 high / 8 low); 1,000 ticks occur in 16,000 cycles.
- Request 500000: tw=4194304, period 4 cycles, 2 high / 2 low. Request 10000: tw=83886; over 2,000,000 cycles tick count is 9999 or 10000.
- Request 600000, then request 9999: req_err pulses once each, tw and cur_freq keep the previous value, output is undisturbed, req_ready stays 1.
- Issue 125000, then pulse req_valid with 250000 while busy: the second request is ignored, and the final tw is 1048576.
- Start a 100000 request, assert rst_n mid-CALC: all outputs return to reset values immediately. After release, a fresh 100000 request gives tw=838860.
- Switch 125000 -> 250000 during output-high (both macro settings): without the macro there is no pulse shorter than 2 cycles; with the macro clk_gen_out=0 in the cycle after LOAD.

Source files
------------

// File: rtl/freq_synth_if.sv
// Request/status bundle for the programmable square-wave generator freq_synth.
// The master side issues frequency requests; the slave side is the synthesizer.
interface freq_synth_if;
    logic [31:0] freq_req;
    logic        req_valid;
    logic        req_ready;
    logic        busy;
    logic        load_done;
    logic        req_err;
    logic [31:0] cur_freq;
    logic        clk_gen_out;
    logic        tick;

    modport master (
        output freq_req,
        output req_valid,
        input  req_ready,
        input  busy,
        input  load_done,
        input  req_err,
        input  cur_freq,
        input  clk_gen_out,
        input  tick
    );

    modport slave (
        input  freq_req,
        input  req_valid,
        output req_ready,
        output busy,
        output load_done,
        output req_err,
        output cur_freq,
        output clk_gen_out,
        output tick
    );
endinterface

// File: rtl/freq_synth.sv
// Phase-accumulator clock generator: tuning word = floor(f * 2^ACC_W / SYS_CLK_FREQ) by serial divider.
// Optional macro FREQ_SYNTH_PHASE_RST_EN restarts the accumulator at phase 0 on every new tuning word.
module freq_synth #(
    parameter int SYS_CLK_FREQ = 2000000,
    parameter int ACC_W        = 24,
    parameter int F_MIN        = 10000,
    parameter int F_MAX        = 500000
) (
    input  logic         sys_clk,
    input  logic         rst_n,
    freq_synth_if.slave  bus
);

    localparam int                CNT_W    = $clog2(ACC_W);
    localparam logic [CNT_W-1:0]  LAST_BIT = CNT_W'(ACC_W - 1);
    localparam logic [33:0]       SYS_W    = 34'(SYS_CLK_FREQ);
    localparam logic [31:0]       F_MIN_W  = 32'(F_MIN);
    localparam logic [31:0]       F_MAX_W  = 32'(F_MAX);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t             r_state;
    logic [31:0]        r_freq_lat;
    logic [32:0]        r_rem;
    logic [ACC_W-1:0]   r_q;
    logic [CNT_W-1:0]   r_bit_cnt;
    logic [ACC_W-1:0]   r_tw;
    logic [31:0]        r_cur_freq;
    logic               r_ready;
    logic               r_busy;
    logic               r_load_done;
    logic               r_req_err;

    logic [ACC_W-1:0]   r_acc;
    logic               r_clk_out;
    logic               r_tick;

    logic               w_accept;
    logic               w_in_range;
    logic [33:0]        w_step;

    // One restoring-division step: returns {quotient bit, next remainder}.
    // The remainder stays below SYS_CLK_FREQ, so its double fits in 34 bits.
    function automatic logic [33:0] div_step(input logic [32:0] rem);
        logic [33:0] r2;
        r2 = {rem, 1'b0};
        if (r2 >= SYS_W) begin
            r2       = r2 - SYS_W;
            div_step = {1'b1, r2[32:0]};
        end else begin
            div_step = {1'b0, r2[32:0]};
        end
    endfunction

    assign w_accept   = bus.req_valid & r_ready;
    assign w_in_range = (bus.freq_req >= F_MIN_W) && (bus.freq_req <= F_MAX_W);
    assign w_step     = div_step(r_rem);

    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_freq_lat  <= '0;
            r_rem       <= '0;
            r_q         <= '0;
            r_bit_cnt   <= '0;
            r_tw        <= '0;
            r_cur_freq  <= '0;
            r_ready     <= 1'b1;
            r_busy      <= 1'b0;
            r_load_done <= 1'b0;
            r_req_err   <= 1'b0;
        end else begin
            r_load_done <= 1'b0;
            r_req_err   <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        if (w_in_range) begin
                            r_freq_lat <= bus.freq_req;
                            r_rem      <= {1'b0, bus.freq_req};
                            r_q        <= '0;
                            r_bit_cnt  <= LAST_BIT;
                            r_ready    <= 1'b0;
                            r_busy     <= 1'b1;
                            r_state    <= S_CALC;
                        end else begin
                            r_req_err  <= 1'b1;
                        end
                    end
                end
                // Quotient bits arrive MSB first; ACC_W steps fill the whole word.
                S_CALC: begin
                    r_rem     <= w_step[32:0];
                    r_q       <= {r_q[ACC_W-2:0], w_step[33]};
                    r_bit_cnt <= r_bit_cnt - 1'b1;
                    if (r_bit_cnt == '0) begin
                        r_state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    r_tw        <= r_q;
                    r_cur_freq  <= r_freq_lat;
                    r_load_done <= 1'b1;
                    r_ready     <= 1'b1;
                    r_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // The accumulator keeps running across a tuning-word change unless phase restart is built in.
    always_ff @(posedge sys_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end
`ifdef FREQ_SYNTH_PHASE_RST_EN
        else if (r_state == S_LOAD) begin
            r_acc     <= '0;
            r_clk_out <= 1'b0;
            r_tick    <= 1'b0;
        end
`endif
        else begin
            r_acc     <= r_acc + r_tw;
            r_clk_out <= r_acc[ACC_W-1];
            r_tick    <= r_acc[ACC_W-1] & ~r_clk_out;
        end
    end

    assign bus.req_ready   = r_ready;
    assign bus.busy        = r_busy;
    assign bus.load_done   = r_load_done;
    assign bus.req_err     = r_req_err;
    assign bus.cur_freq    = r_cur_freq;
    assign bus.clk_gen_out = r_clk_out;
    assign bus.tick        = r_tick;

endmodule
